// File: rtl/mem8x8_pkg.sv
// Shared types and constants for the mem8x8 host-side request logic.
package mem8x8_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem8x8_host_initiator_cmd_fifo.sv
// Command queue for the host initiator: circular buffer with occupancy count.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem8x8_host_initiator.sv
// Requesting side of the mem8x8 controller handshake: queues client commands,
// drives op/sel/addr/data toward the controller and returns one response each.
module mem8x8_host_initiator
  import mem8x8_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              op,
  output logic              sel,
  input  logic              valid,
  input  logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q;
  logic                op_q;
  logic                sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                data_oe_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_error_q;
  logic [7:0]          wait_q;

  logic [CMD_W-1:0]      fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_pop;
  logic                  head_write;
  logic [ADDR_W-1:0]     head_addr;
  logic [DATA_W-1:0]     head_wdata;
  logic                  ack;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_write, cmd_addr, cmd_wdata}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_write = fifo_head[CMD_W-1];
  assign head_addr  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign head_wdata = fifo_head[DATA_W-1:0];

  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  // A valid carrying the other rw means the controller is still switching.
  assign ack       = valid && (rw == op_q);

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign op        = op_q;
  assign sel       = sel_q;
  assign addr      = addr_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ISSUE;
            op_q       <= head_write;
            addr_q     <= head_addr;
            data_out_q <= head_wdata;
            data_oe_q  <= (head_write == OP_WRITE);
            sel_q      <= 1'b1;
            wait_q     <= '0;
          end
        end
        ISSUE: begin
          if (ack) begin
            state_q     <= DONE;
            sel_q       <= 1'b0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= (op_q == OP_WRITE) ? '0 : data_in;
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= DONE;
            sel_q       <= 1'b0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          // Bus-turnaround cycle: addr/op hold, request and drive stay low.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem8x8_host_initiator.sv
// Randomised scoreboard bench for mem8x8_host_initiator with a behavioural
// controller/memory model on the far side of the handshake.
module tb_mem8x8_host_initiator;
  import mem8x8_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       op, sel;
  logic       valid = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       busy;

  always #5 clk = ~clk;

  mem8x8_host_initiator #(
    .ADDR_W (3), .DATA_W (8), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .op (op), .sel (sel), .valid (valid), .rw (rw),
    .addr (addr), .data_out (data_out), .data_oe (data_oe), .data_in (data_in),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_error (rsp_error),
    .busy (busy)
  );

  typedef struct {
    cmd_t c;
    int   d;     // sel-high cycle index on which the controller acknowledges
    bit   mism;  // present valid with the wrong rw before the acknowledge
    bit   to;    // never acknowledge
  } plan_t;

  typedef struct {
    bit         err;
    logic [7:0] rdata;
  } exp_t;

  int     checks = 0;
  int     failures = 0;
  plan_t  plan_q[$];
  exp_t   exp_q[$];
  logic [7:0] model_mem [8];
  logic [7:0] ctrl_mem [8];
  int     pushes_done = 0;
  int     issued_cnt = 0;
  bit     saw_full = 0;
  int     rsp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  logic prev_rsp = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rsp = 1'b0;
    end else begin
      if (rsp_valid) begin
        check("rsp_pulse", prev_rsp, 0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          rsp_cnt++;
          $display("rsp %0d: err=%0d rdata=%02h (exp err=%0d rdata=%02h)",
                   rsp_cnt, rsp_error, rsp_rdata, mon_e.err, mon_e.rdata);
          check("rsp_error", rsp_error, mon_e.err);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  // Controller + memory model: answers each request according to its plan.
  bit    ctl_active = 0;
  int    ctl_k = 0;
  plan_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      ctl_active = 0;
      valid = 1'b0;
      rw = 1'b0;
      data_in = '0;
    end else if (sel) begin
      if (!ctl_active) begin
        ctl_active = 1;
        ctl_k = 0;
        issued_cnt++;
        if (plan_q.size() == 0) begin
          check("issue_unexpected", 1, 0);
          cur.to = 1;
        end else begin
          cur = plan_q.pop_front();
          check("op", op, cur.c.write);
          check("addr", addr, cur.c.addr);
          check("data_oe", data_oe, cur.c.write);
          if (cur.c.write) check("data_out", data_out, cur.c.wdata);
        end
      end else begin
        ctl_k++;
      end
      valid = 1'b0;
      rw = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      if (!cur.to && ctl_k >= cur.d) begin
        valid = 1'b1;
        rw = cur.c.write;
        if (cur.c.write) ctrl_mem[cur.c.addr] = cur.c.wdata;
        else data_in = ctrl_mem[cur.c.addr];
      end else if (cur.mism || (cur.to && $urandom_range(0, 1) == 1)) begin
        valid = 1'b1;
        rw = !cur.c.write;
      end
    end else begin
      if (ctl_active) begin
        ctl_active = 0;
        check("sel_cycles", ctl_k + 1, cur.to ? TIMEOUT : cur.d + 1);
      end
      check("oe_when_unselected", data_oe, 0);
      // Stray acknowledges outside a request must be ignored.
      valid = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
    end
  end

  task automatic push_cmd(input bit w, input logic [2:0] a, input logic [7:0] wd,
                          input int d, input bit mism, input bit to);
    plan_t p;
    exp_t  e;
    int    budget = 0;
    bit    done = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      check("cmd_ready", cmd_ready, (pushes_done - issued_cnt) < DEPTH);
      if (!cmd_ready) saw_full = 1;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = wd;
      if (cmd_ready) begin
        p.c.write = w; p.c.addr = a; p.c.wdata = wd;
        p.d = d; p.mism = mism; p.to = to;
        if (to) begin
          e.err = 1; e.rdata = 8'h00;
        end else if (w) begin
          model_mem[a] = wd;
          e.err = 0; e.rdata = 8'h00;
        end else begin
          e.err = 0; e.rdata = model_mem[a];
        end
        plan_q.push_back(p);
        exp_q.push_back(e);
        pushes_done++;
        done = 1;
      end else if (++budget > 500) begin
        check("push_wait_expired", 1, 0);
        cmd_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 0;
    idle_cycles(1);
    while ((exp_q.size() != 0 || busy) && budget < 3000) begin
      idle_cycles(1);
      budget++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("busy_after_drain", busy, 0);
  endtask

  initial begin
    foreach (ctrl_mem[i]) begin
      ctrl_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    cur.to = 1; cur.d = 0; cur.mism = 0; cur.c = '0;

    #1;
    check("rst_sel", sel, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op_addr", {op, addr, data_out, rsp_rdata, rsp_error}, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed: writes, read-back, rw mismatch, timeout, follow-on read.
    push_cmd(1, 3'd5, 8'h3C, 1, 0, 0);
    push_cmd(1, 3'd3, 8'hA5, 1, 0, 0);
    push_cmd(0, 3'd3, 8'h00, 1, 0, 0);
    push_cmd(1, 3'd6, 8'h77, 2, 1, 0);
    push_cmd(0, 3'd4, 8'h00, 0, 0, 1);
    push_cmd(0, 3'd5, 8'h00, 0, 0, 0);
    drain();

    // Stall the controller to fill the queue; acknowledge on the last allowed cycle.
    saw_full = 0;
    push_cmd(0, 3'd1, 8'h00, TIMEOUT - 1, 0, 0);
    for (int i = 0; i < 5; i++) push_cmd(1, 3'(i), 8'(8'h10 + i), 0, 0, 0);
    drain();
    check("fifo_reached_full", saw_full, 1);

    // Reset in the middle of a stalled transaction with commands queued.
    push_cmd(0, 3'd2, 8'h00, 0, 0, 1);
    push_cmd(1, 3'd7, 8'h99, 0, 0, 0);
    push_cmd(0, 3'd7, 8'h00, 0, 0, 0);
    idle_cycles(4);
    check("pre_reset_sel", sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sel", sel, 0);
    check("midrst_data_oe", data_oe, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    plan_q.delete();
    exp_q.delete();
    pushes_done = 0;
    issued_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    model_mem = ctrl_mem;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      check("post_rst_sel", sel, 0);
      check("post_rst_busy", busy, 0);
    end

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      int  d;
      bit  to;
      to = ($urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
      push_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
               d, 1'($urandom_range(0, 1)), to);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 4)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
